gf29_reduce: RTL and testbench



---
 rtl/gf29_reduce.sv | 148 ++++++++++++++
 tb/tb_gf29_reduce.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf29_reduce.sv
// GF(2^29) reduction unit: reduces a 59-bit carry-less product modulo
// P(x) = x^29 + x^2 + 1 and hands the 29-bit result out over a valid/ready port.
// Build variant: define GF29_SINGLE_CYCLE_EN for a one-cycle two-fold reducer;
// otherwise the block reduces one bit per cycle from degree 58 down to 29.
module gf29_reduce (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [58:0] in_prod,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [28:0] out_res,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StReduce,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [58:0] r_q, r_d;
  logic [28:0] res_q, res_d;
  logic        valid_q, valid_d;

  // Work register after this cycle's reduction work, and whether it is final.
  logic [58:0] r_red;
  logic        last_step;

`ifdef GF29_SINGLE_CYCLE_EN
  logic [29:0] hi1;
  logic [31:0] fold1;
  logic [2:0]  hi2;
  logic [28:0] fold2;

  // Two folds of x^29 = x^2 + 1: the first leaves at most degree 31, the second
  // at most degree 4, so the result always fits in 29 bits.
  always_comb begin
    hi1       = r_q[58:29];
    fold1     = {3'b000, r_q[28:0]} ^ {hi1, 2'b00} ^ {2'b00, hi1};
    hi2       = fold1[31:29];
    fold2     = fold1[28:0] ^ {24'd0, hi2, 2'b00} ^ {26'd0, hi2};
    r_red     = {30'd0, fold2};
    last_step = 1'b1;
  end
`else
  logic [5:0]  d_q, d_d;
  logic [58:0] r_shift;

  // One bit per cycle: a set coefficient at x^d is replaced by x^(d-27) + x^(d-29).
  always_comb begin
    r_shift   = r_q >> d_q;
    r_red     = r_q;
    if (r_shift[0]) begin
      r_red = r_q ^ (59'd1 << d_q) ^ (59'd1 << (d_q - 6'd27)) ^ (59'd1 << (d_q - 6'd29));
    end
    last_step = (d_q == 6'd29);
  end

  // Bit index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 6'd0;
    end else begin
      d_q <= d_d;
    end
  end
`endif

  // Next-state logic; flush overrides every accept or handshake.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    res_d   = res_q;
    valid_d = valid_q;
`ifndef GF29_SINGLE_CYCLE_EN
    d_d     = d_q;
`endif
    if (flush) begin
      state_d = StIdle;
      valid_d = 1'b0;
      r_d     = 59'd0;
`ifndef GF29_SINGLE_CYCLE_EN
      d_d     = 6'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            r_d     = in_prod;
            state_d = StReduce;
`ifndef GF29_SINGLE_CYCLE_EN
            d_d     = 6'd58;
`endif
          end
        end
        StReduce: begin
          r_d = r_red;
`ifndef GF29_SINGLE_CYCLE_EN
          d_d = d_q - 6'd1;
`endif
          if (last_step) begin
            state_d = StDone;
            res_d   = r_red[28:0];
            valid_d = 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, work register and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= 59'd0;
      res_q   <= 29'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  // Output decode; in_ready is masked by flush so an aborted cycle never accepts.
  always_comb begin
    in_ready  = (state_q == StIdle) && !flush;
    busy      = (state_q != StIdle);
    out_valid = valid_q;
    out_res   = res_q;
  end

endmodule

// File: tb/tb_gf29_reduce.sv
// Bench for gf29_reduce: scoreboard of expected results fed by the stimulus,
// drained by a monitor on the output handshake. Reference results come from a
// table of x^i mod P(x) built by repeated multiplication by x.
module tb_gf29_reduce;

`ifdef GF29_SINGLE_CYCLE_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 31;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [58:0] in_prod;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_res;
  logic        busy;

  gf29_reduce dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [28:0] exp_q[$];
  int unsigned acc_q[$];
  logic [28:0] pow_tab[59];
  bit          rand_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // x^i mod P(x) for i = 0..58.
  initial begin
    logic [29:0] cur;
    cur = 30'd1;
    for (int i = 0; i < 59; i++) begin
      pow_tab[i] = cur[28:0];
      cur = cur << 1;
      if (cur[29]) cur = cur ^ 30'h2000_0005;
    end
  end

  function automatic logic [28:0] ref_mod(input logic [58:0] p);
    logic [28:0] acc;
    acc = 29'd0;
    for (int i = 0; i < 59; i++) if (p[i]) acc = acc ^ pow_tab[i];
    return acc;
  endfunction

  // Monitor: sample at the falling edge, when everything driven after the
  // rising edge has settled.
  logic        prev_hold = 1'b0;
  logic        prev_hs   = 1'b0;
  logic        prev_ov   = 1'b0;
  logic [28:0] prev_res  = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_hs   = 1'b0;
      prev_ov   = 1'b0;
    end else begin
      chk("in_ready vs state/flush", in_ready, !busy && !flush);
      if (prev_hold) begin
        chk("out_valid held", out_valid, 1'b1);
        chk("out_res held", out_res, prev_res);
      end
      if (prev_hs) begin
        chk("out_valid after handshake", out_valid, 1'b0);
        chk("in_ready after handshake", in_ready, !flush);
      end
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          chk("latency: output without accept", 1, 0);
        end else begin
          chk("latency", cyc - acc_q.pop_front(), Lat - 1);
        end
      end
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected output", out_res, 64'hdead);
        end else begin
          chk("out_res", out_res, exp_q.pop_front());
        end
      end
      prev_hold = out_valid && !out_ready && !flush;
      prev_hs   = out_valid && out_ready && !flush;
      prev_ov   = out_valid;
      prev_res  = out_res;
    end
  end

  // Random consumer stalls during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product; the expected result is queued at the accepting edge.
  task automatic send(input logic [58:0] p, input logic [28:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk("accept timeout", 1, 0);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      step();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("out_valid reached", out_valid, 1'b1);
  endtask

  initial begin
    logic [63:0] w;
    logic [58:0] p;
    logic [28:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset out_res", out_res, 29'd0);
    repeat (3) step();
    rst_n = 1'b1;

    // Directed values; first accept on the first edge after reset release.
    send(59'd0, 29'h0);
    chk("busy after first accept", busy, 1'b1);
    drain();
    send(59'd1 << 29, 29'h5);
    drain();
    send(59'd1 << 58, 29'h11);
    drain();
    send(59'h1234567, 29'h1234567);
    drain();

    // Hold the result with out_ready low; in_valid must be ignored.
    out_ready = 1'b0;
    send(59'd1 << 29, 29'h5);
    wait_valid();
    repeat (10) begin
      in_valid = 1'b1;
      in_prod  = 59'($urandom());
      step();
      chk("stall in_ready", in_ready, 1'b0);
      chk("stall out_valid", out_valid, 1'b1);
      chk("stall out_res", out_res, 29'h5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-reduction.
    send(59'h7ff_ffff_ffff_ffff, ref_mod(59'h7ff_ffff_ffff_ffff));
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 1'b0);
    chk("async rst in_ready", in_ready, 1'b1);
    chk("async rst busy", busy, 1'b0);
    chk("async rst out_res", out_res, 29'd0);
    exp_q.delete();
    acc_q.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("no output after reset", out_valid, 1'b0);
    send(59'd1 << 29, 29'h5);
    drain();

    // Flush mid-reduction together with in_valid: no accept, no output.
    held = out_res;
    send(59'd1 << 40, 29'h0);
    repeat (14) step();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_prod  = 59'd1 << 29;
    #1;
    chk("in_ready during flush", in_ready, 1'b0);
    step();
    chk("flush busy", busy, 1'b0);
    chk("flush out_valid", out_valid, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    // Flush in IDLE with in_valid.
    flush    = 1'b1;
    in_valid = 1'b1;
    step();
    chk("idle flush no accept", busy, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (40) step();
    chk("no output after flush", out_valid, 1'b0);
    chk("out_res kept after flush", out_res, held);

    // Flush beats a result handshake in DONE; out_res keeps its value.
    out_ready = 1'b0;
    send(59'd1 << 58, 29'h11);
    wait_valid();
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("done flush out_valid", out_valid, 1'b0);
    chk("done flush busy", busy, 1'b0);
    chk("done flush out_res", out_res, 29'h11);
    exp_q.delete();
    acc_q.delete();
    step();

    // Random products with random consumer stalls.
    rand_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = {$urandom(), $urandom()};
      p = w[58:0];
      if (i % 50 != 0) p[58:57] = 2'b00;
      repeat ($urandom_range(0, 2)) step();
      send(p, ref_mod(p));
    end
    drain();
    rand_stall = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
